student_fir_requant_fifo: RTL
=============================

Name: student_fir_requant_fifo

Overview:
Downstream stage of the FIR core. It consumes the FIR accumulator result (y word plus valid strobe) and requantizes it to a DATA_SIZE-bit signed sample: arithmetic right shift, optional round-half-up, then saturation. Results are buffered in a small show-ahead FIFO with a valid/ready output towards the DAC/I2S transmitter. Saturation events and FIFO overflow are counted for software visibility.

Parameters:
DATA_SIZE_FIR_OUT, 32, width of the incoming accumulator word (two's complement)
DATA_SIZE, 16, width of the output sample (two's complement)
FIFO_DEPTH, 8, number of FIFO entries; must be a power of 2 and at least 2
CNT_WIDTH, 16, width of the saturation and drop counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
valid_strobe_in  in  1  FIR result valid; rising edge qualifies y_in
y_in  in  DATA_SIZE_FIR_OUT  FIR accumulator, signed
shift_i  in  5  right-shift amount (0..31), sampled with y_in
round_en_i  in  1  1 = round-half-up before truncation, sampled with y_in
clear_i  in  1  synchronous flush of FIFO, pipeline, counters and sticky flag
sample_o  out  DATA_SIZE  FIFO head sample
sample_valid_o  out  1  FIFO non-empty
sample_ready_i  in  1  consumer accepts head when high together with sample_valid_o
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current occupancy
sat_count_o  out  CNT_WIDTH  number of saturated results
drop_count_o  out  CNT_WIDTH  number of results dropped because the FIFO was full
overflow_o  out  1  sticky, set on the first drop

Behaviour:
- Reset: all outputs are 0; FIFO empty; pipeline valids are 0; the edge-detect history register is 0.
- Strobe qualification: capture = valid_strobe_in & ~valid_strobe_in_q. A held-high strobe yields exactly one capture.
- Stage S1 (end of capture cycle C): register y_in, shift_i, round_en_i, and set s1_valid.
- Stage S2 (end of C+1):
  - r = (sign-extended y, DATA_SIZE_FIR_OUT+1 bits) + (round_en && shift>0 ? 1<<(shift-1) : 0).
  - Then r >>> shift (arithmetic). The extra bit ensures rounding never wraps.
- Stage S3 (end of C+2):
  - Saturate to signed DATA_SIZE: >2^(DATA_SIZE-1)-1 gives 0x7FFF; <-2^(DATA_SIZE-1) gives 0x8000.
  - Each saturation increments sat_count_o.
  - The result is pushed into the FIFO.
- Latency: capture in cycle C, so sample_valid_o=1 with data on sample_o in cycle C+3 if the FIFO was empty. Throughput is one capture per 2 cycles minimum (edge detect).
- FIFO: first-word-fall-through. Pop when sample_valid_o && sample_ready_i. sample_o = 0 when empty. Pointers wrap modulo FIFO_DEPTH; occupancy is tracked in fifo_level_o.
- Full with push and no pop: push is discarded, drop_count_o increments, overflow_o is set. Full with push and pop in the same cycle: both proceed, level unchanged, no drop. Empty with push: level becomes 1 next cycle; no same-cycle bypass.
- Counters saturate at all-ones and never wrap.
- clear_i: on the next edge, FIFO is emptied, s1/s2 valids cleared, counters and overflow_o zeroed, edge history kept. A capture in the same cycle as clear_i is discarded. clear_i has priority over push and pop.
- Async reset mid-operation: everything returns to reset values immediately, and in-flight results are lost.

Test Plan:
- Round and shift: y_in=0x0000C000, shift=15. round_en=1 gives sample_o=0x0002; round_en=0 gives 0x0001. Both appear exactly 3 cycles after the strobe rising edge.
- Negative: y_in=0xFFFF4000, shift=15. round_en=1 gives 0xFFFF; round_en=0 gives 0xFFFE. sat_count_o stays 0.
- Saturation:
  - y_in=0x7FFFFFFF, shift=0 gives 0x7FFF.
  - y_in=0x80000000, shift=0 gives 0x8000.
  - y_in=0x7FFFFFFF, shift=16, round_en=1 gives 0x7FFF (rounding carry, no wrap).
  - sat_count_o=3 after all three.
- Overflow: sample_ready_i=0, 10 strobes with y_in=1..10 and shift=0. Expect fifo_level_o=8, drop_count_o=2, overflow_o=1. Then sample_ready_i=1 pops 1..8 in order and ends with sample_valid_o=0.
- Held strobe and full push+pop: valid_strobe_in held high 6 cycles gives exactly one entry. With FIFO full, a capture and a pop landing in the same cycle leave level at 8 and drop_count_o unchanged.
- clear_i and reset: with 3 entries queued and 1 result in S2, clear_i gives level 0, valid 0, counters 0 and no late push. Asserting rst_ni=0 mid-stream zeroes all outputs asynchronously.

Source files
------------

// File: rtl/student_fir_requant_fifo_if.sv
// Handshake bundle between the FIR core, the requantizer/FIFO stage and the
// sample consumer.
interface student_fir_requant_fifo_if #(
  parameter int unsigned DATA_SIZE_FIR_OUT = 32,
  parameter int unsigned DATA_SIZE         = 16,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned CNT_WIDTH         = 16
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                         valid_strobe_in;
  logic [DATA_SIZE_FIR_OUT-1:0] y_in;
  logic [4:0]                   shift_i;
  logic                         round_en_i;
  logic                         clear_i;
  logic [DATA_SIZE-1:0]         sample_o;
  logic                         sample_valid_o;
  logic                         sample_ready_i;
  logic [LVL_W-1:0]             fifo_level_o;
  logic [CNT_WIDTH-1:0]         sat_count_o;
  logic [CNT_WIDTH-1:0]         drop_count_o;
  logic                         overflow_o;

  modport master (
    output valid_strobe_in, y_in, shift_i, round_en_i, clear_i, sample_ready_i,
    input  sample_o, sample_valid_o, fifo_level_o, sat_count_o, drop_count_o, overflow_o
  );

  modport slave (
    input  valid_strobe_in, y_in, shift_i, round_en_i, clear_i, sample_ready_i,
    output sample_o, sample_valid_o, fifo_level_o, sat_count_o, drop_count_o, overflow_o
  );
endinterface

// File: rtl/student_fir_requant_fifo.sv
// Requantizes FIR accumulator words (shift, optional round-half-up, saturate)
// and buffers them in a show-ahead FIFO with saturation/drop statistics.
module student_fir_requant_fifo #(
  parameter int unsigned DATA_SIZE_FIR_OUT = 32,
  parameter int unsigned DATA_SIZE         = 16,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  student_fir_requant_fifo_if.slave bus
);
  localparam int unsigned W1    = DATA_SIZE_FIR_OUT + 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 1;
  localparam logic signed [W1-1:0] SAT_MAX = {{(W1-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [W1-1:0] SAT_MIN = {{(W1-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  logic                         stb_q, stb_d;
  logic [DATA_SIZE_FIR_OUT-1:0] s1_y_q, s1_y_d;
  logic [4:0]                   s1_sh_q, s1_sh_d;
  logic                         s1_rnd_q, s1_rnd_d;
  logic                         s1_valid_q, s1_valid_d;
  logic signed [W1-1:0]         s2_val_q, s2_val_d;
  logic                         s2_valid_q, s2_valid_d;
  logic [DATA_SIZE-1:0]         mem_q [FIFO_DEPTH];
  logic [DATA_SIZE-1:0]         mem_d [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]             level_q, level_d;
  logic [CNT_WIDTH-1:0]         sat_cnt_q, sat_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                         ovf_q, ovf_d;

  logic                         capture, push, pop, full, wr_en, drop, sat_hi, sat_lo;
  logic signed [W1-1:0]         rnd_add, rsum;
  logic [DATA_SIZE-1:0]         sat_val;

  always_comb begin
    stb_d      = bus.valid_strobe_in;
    capture    = bus.valid_strobe_in & ~stb_q;
    s1_y_d     = s1_y_q;
    s1_sh_d    = s1_sh_q;
    s1_rnd_d   = s1_rnd_q;
    if (capture) begin
      s1_y_d   = bus.y_in;
      s1_sh_d  = bus.shift_i;
      s1_rnd_d = bus.round_en_i;
    end
    s1_valid_d = capture & ~bus.clear_i;

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    rnd_add = '0;
    if (s1_rnd_q && (s1_sh_q != 5'd0)) rnd_add = W1'(1) << (s1_sh_q - 5'd1);
    rsum       = $signed({s1_y_q[DATA_SIZE_FIR_OUT-1], s1_y_q}) + rnd_add;
    s2_val_d   = s1_valid_q ? (rsum >>> s1_sh_q) : s2_val_q;
    s2_valid_d = s1_valid_q & ~bus.clear_i;

    sat_hi  = s2_val_q > SAT_MAX;
    sat_lo  = s2_val_q < SAT_MIN;
    sat_val = sat_hi ? {1'b0, {(DATA_SIZE-1){1'b1}}} :
              sat_lo ? {1'b1, {(DATA_SIZE-1){1'b0}}} : s2_val_q[DATA_SIZE-1:0];

    push  = s2_valid_q;
    pop   = (level_q != '0) & bus.sample_ready_i;
    full  = level_q == LVL_W'(FIFO_DEPTH);
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    sat_cnt_d  = sat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;

    if (bus.clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      sat_cnt_d  = '0;
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = sat_val;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !pop) level_d = level_q + LVL_W'(1);
      else if (!wr_en && pop) level_d = level_q - LVL_W'(1);
      if (push && (sat_hi || sat_lo) && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q      <= 1'b0;
      s1_y_q     <= '0;
      s1_sh_q    <= '0;
      s1_rnd_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_val_q   <= '0;
      s2_valid_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      stb_q      <= stb_d;
      s1_y_q     <= s1_y_d;
      s1_sh_q    <= s1_sh_d;
      s1_rnd_q   <= s1_rnd_d;
      s1_valid_q <= s1_valid_d;
      s2_val_q   <= s2_val_d;
      s2_valid_q <= s2_valid_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.sample_o       = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign bus.sample_valid_o = level_q != '0;
  assign bus.fifo_level_o   = level_q;
  assign bus.sat_count_o    = sat_cnt_q;
  assign bus.drop_count_o   = drop_cnt_q;
  assign bus.overflow_o     = ovf_q;
endmodule
